// File: rtl/core_pkg.sv
// Shared RV32I core constants: data width, memory geometry and store-width encodings.
package core_pkg;
  localparam int XLEN           = 32;
  localparam int DATA_MEM_SIZE  = 4096;
  localparam int DATA_ADDR_SIZE = 11;
  localparam int INST_MEM_SIZE  = 1024;
  localparam int INST_ADDR_SIZE = 9;

  // funct3 store widths; the upstream masking uses these to zero-extend sb/sh data
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_width_e;
endpackage

// File: rtl/memory_data_if.sv
// Data-memory bus: asynchronous read port plus single-word synchronous write port.
interface memory_data_if;
  import core_pkg::*;
  logic [XLEN-1:0] read_addr;
  logic [XLEN-1:0] read_data;
  logic [XLEN-1:0] write_addr;
  logic [XLEN-1:0] write_data;
  logic            write_enable;

  modport master (output read_addr, write_addr, write_data, write_enable, input read_data);
  modport slave  (input read_addr, write_addr, write_data, write_enable, output read_data);
endinterface

// File: rtl/memory_data.sv
// Word-organised data memory: combinational read, one full-word write per cycle.
// Define MEMORY_DATA_INIT_FILE_EN to keep contents across reset.
module memory_data
  import core_pkg::*;
#(
  parameter int    MEM_SIZE  = DATA_MEM_SIZE,
  parameter int    ADDR_SIZE = DATA_ADDR_SIZE,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  memory_data_if.slave  bus
);
  localparam int DEPTH = MEM_SIZE / 4;

  logic [XLEN-1:0]      mem_q [DEPTH];
  logic [ADDR_SIZE-2:0] rd_idx;
  logic [ADDR_SIZE-2:0] wr_idx;

  // Byte-offset bits and bits above ADDR_SIZE are dropped, so addresses alias mod MEM_SIZE.
  assign rd_idx        = bus.read_addr[ADDR_SIZE:2];
  assign wr_idx        = bus.write_addr[ADDR_SIZE:2];
  assign bus.read_data = mem_q[rd_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.read_addr[XLEN-1:ADDR_SIZE+1], bus.read_addr[1:0],
                              bus.write_addr[XLEN-1:ADDR_SIZE+1], bus.write_addr[1:0]};

`ifdef MEMORY_DATA_INIT_FILE_EN
  localparam bit init_file_unused = (INIT_FILE == "");

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Contents survive reset; reset only blocks the write.
  always @(posedge clk) begin
    if (rst && bus.write_enable) mem_q[wr_idx] <= bus.write_data;
  end
`else
  localparam bit init_file_unused = (INIT_FILE == "");

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.write_enable) begin
      mem_q[wr_idx] <= bus.write_data;
    end
  end
`endif
endmodule

// File: tb/tb_memory_data.sv
// Directed bench for memory_data: vector table plus hand sequences for read-during-write.
module tb_memory_data;
  logic clk = 1'b0;
  logic rst = 1'b0;
  memory_data_if bus ();

  memory_data dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst                  = v.rst;
    bus.write_enable     = v.we;
    bus.write_addr       = v.waddr;
    bus.write_data       = v.wdata;
    bus.read_addr        = v.raddr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.read_addr    = '0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.write_enable = 1'b0;

    //          rst   we    waddr         wdata         raddr         exp
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0022, 32'h0000_0004, 32'h0000_0022};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0000_0033, 32'h0000_0FFC, 32'h0000_0033};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0FFC, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0011, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_1FFC, 32'hA5A5_A5A5};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFF};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_00AB, 32'h0000_0008, 32'h0000_00AB};
    vecs[16] = '{1'b1, 1'b1, 32'h0000_000A, 32'h0000_0077, 32'h0000_0008, 32'h0000_0077};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000};

    // Initial reset edge before the table.
    @(posedge clk);
    #1;
    check("reset_word0", bus.read_data, 32'h0);

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d", i), bus.read_data, vecs[i].exp);
    end

    // Read port is combinational: a new address shows up without a clock edge.
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_addr    = 32'h0000_0FFC;
    #1;
    check("comb_read_ffc", bus.read_data, 32'hA5A5_A5A5);
    bus.read_addr = 32'h8000_1009;
    #1;
    check("comb_read_alias_8", bus.read_data, 32'h0000_0077);

    // Same-address read during write: old word before the edge, new word after.
    apply('{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0001, 32'h0000_0040, 32'h0});
    check("rdw_setup", bus.read_data, 32'h0000_0001);
    @(negedge clk);
    bus.write_data = 32'h0000_0002;
    #1;
    check("rdw_before_edge", bus.read_data, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("rdw_after_edge", bus.read_data, 32'h0000_0002);

    // Reset with a pending write: reset wins and the whole array clears.
    @(negedge clk);
    rst              = 1'b0;
    bus.write_addr   = 32'h0000_0044;
    bus.write_data   = 32'hCAFE_F00D;
    bus.read_addr    = 32'h0000_0044;
    @(posedge clk);
    #1;
    check("rst_beats_write", bus.read_data, 32'h0);
    bus.read_addr = 32'h0000_0040;
    #1;
    check("rst_clears_40", bus.read_data, 32'h0);
    @(negedge clk);
    rst              = 1'b1;
    bus.write_enable = 1'b0;
    bus.read_addr    = 32'h0000_0008;
    #1;
    check("rst_clears_8", bus.read_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
